tile_dma: RTL and testbench

Parametrised strided copy engine between DRAM and the GLB, the next generation of the tiling data mover. A single command moves a 3-D region (planes × rows × row_bytes) in either direction, with independent source and destination strides. Partial-word row tails on GLB writes are handled with byte masks. It sits between the tile controller and the two memory ports, and is sequenced by the controller with a start/finish handshake.

---
 rtl/tile_dma_if.sv | 50 +++++
 rtl/tile_dma.sv | 245 ++++++++++++++++++++++++
 tb/tb_tile_dma.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/tile_dma_if.sv
// Command, status and memory-port bundle for tile_dma.
// The master modport is the engine side; slave is the controller/memory side.
interface tile_dma_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 8,
    parameter int LEN_W      = 16,
    parameter int CNT_W      = 10
);
    logic                    start;
    logic                    mode;
    logic [ADDR_WIDTH-1:0]   src_base;
    logic [ADDR_WIDTH-1:0]   dst_base;
    logic [LEN_W-1:0]        row_bytes;
    logic [CNT_W-1:0]        row_count;
    logic [CNT_W-1:0]        plane_count;
    logic [LEN_W-1:0]        src_row_stride;
    logic [LEN_W-1:0]        dst_row_stride;
    logic [ADDR_WIDTH-1:0]   src_plane_stride;
    logic [ADDR_WIDTH-1:0]   dst_plane_stride;
    logic                    busy;
    logic                    finish;
    logic                    error;
    logic                    dram_we;
    logic [ADDR_WIDTH-1:0]   dram_addr;
    logic [DATA_WIDTH*4-1:0] dram_w_data;
    logic [DATA_WIDTH*4-1:0] dram_r_data;
    logic [3:0]              glb_re;
    logic [3:0]              glb_we;
    logic [ADDR_WIDTH-1:0]   glb_r_addr;
    logic [ADDR_WIDTH-1:0]   glb_w_addr;
    logic [DATA_WIDTH*4-1:0] glb_w_data;
    logic [DATA_WIDTH*4-1:0] glb_r_data;
    logic [31:0]             checksum;

    modport master (
        input  start, mode, src_base, dst_base, row_bytes, row_count, plane_count,
               src_row_stride, dst_row_stride, src_plane_stride, dst_plane_stride,
               dram_r_data, glb_r_data,
        output busy, finish, error, dram_we, dram_addr, dram_w_data,
               glb_re, glb_we, glb_r_addr, glb_w_addr, glb_w_data, checksum
    );

    modport slave (
        output start, mode, src_base, dst_base, row_bytes, row_count, plane_count,
               src_row_stride, dst_row_stride, src_plane_stride, dst_plane_stride,
               dram_r_data, glb_r_data,
        input  busy, finish, error, dram_we, dram_addr, dram_w_data,
               glb_re, glb_we, glb_r_addr, glb_w_addr, glb_w_data, checksum
    );
endinterface

// File: rtl/tile_dma.sv
// tile_dma: strided 3-D copy engine, DRAM->GLB (load) or GLB->DRAM (store), one beat per cycle.
// Optional feature macro TILE_DMA_CHECKSUM_EN: byte-sum of all written (masked) lanes.
module tile_dma #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 8,
    parameter int LEN_W      = 16,
    parameter int CNT_W      = 10
) (
    input  logic      clk,
    input  logic      rst,
    tile_dma_if.master io
);
    localparam int BUS_W = DATA_WIDTH * 4;

    typedef enum logic [1:0] {IDLE, XFER, DRAIN, DONE} state_t;
    state_t state_q, state_d;

    logic                  mode_q, mode_d;
    logic                  error_q, error_d;
    logic [LEN_W-1:0]      row_bytes_q, row_bytes_d;
    logic [CNT_W-1:0]      row_count_q, row_count_d;
    logic [CNT_W-1:0]      plane_count_q, plane_count_d;
    logic [LEN_W-1:0]      src_row_stride_q, src_row_stride_d;
    logic [LEN_W-1:0]      dst_row_stride_q, dst_row_stride_d;
    logic [ADDR_WIDTH-1:0] src_plane_stride_q, src_plane_stride_d;
    logic [ADDR_WIDTH-1:0] dst_plane_stride_q, dst_plane_stride_d;
    logic [ADDR_WIDTH-1:0] src_plane_base_q, src_plane_base_d;
    logic [ADDR_WIDTH-1:0] dst_plane_base_q, dst_plane_base_d;
    logic [ADDR_WIDTH-1:0] src_row_base_q, src_row_base_d;
    logic [ADDR_WIDTH-1:0] dst_row_base_q, dst_row_base_d;
    logic [LEN_W-1:0]      off_q, off_d;
    logic [CNT_W-1:0]      row_q, row_d;
    logic [CNT_W-1:0]      plane_q, plane_d;
    logic                  wr_valid_q, wr_valid_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [3:0]            wr_mask_q, wr_mask_d;

    logic                  accept;
    logic                  illegal_cmd, zero_cmd;
    logic [LEN_W-1:0]      rem;
    logic                  last_in_row, last_row, last_plane, last_beat;
    logic [3:0]            rd_mask;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [BUS_W-1:0]      wr_data;

    assign accept      = (state_q == IDLE) && io.start;
    assign illegal_cmd = io.mode && (io.row_bytes[1:0] != 2'b00);
    assign zero_cmd    = (io.row_bytes == '0) || (io.row_count == '0) || (io.plane_count == '0);
    assign rem         = row_bytes_q - off_q;
    assign last_in_row = rem <= LEN_W'(4);
    assign last_row    = row_q == row_count_q - CNT_W'(1);
    assign last_plane  = plane_q == plane_count_q - CNT_W'(1);
    assign last_beat   = last_in_row && last_row && last_plane;
    assign rd_addr     = src_row_base_q + ADDR_WIDTH'(off_q);
    assign wr_data     = mode_q ? io.glb_r_data : io.dram_r_data;

    // Lane i is live while more than i bytes of the row remain; yields 0001/0011/0111/1111.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_mask
            assign rd_mask[gi] = rem > LEN_W'(gi);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (io.start) state_d = (illegal_cmd || zero_cmd) ? DONE : XFER;
            XFER:    if (last_beat) state_d = DRAIN;
            DRAIN:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Address walk is incremental: row base steps by row stride, plane base by plane stride.
    always_comb begin
        mode_d             = mode_q;
        error_d            = error_q;
        row_bytes_d        = row_bytes_q;
        row_count_d        = row_count_q;
        plane_count_d      = plane_count_q;
        src_row_stride_d   = src_row_stride_q;
        dst_row_stride_d   = dst_row_stride_q;
        src_plane_stride_d = src_plane_stride_q;
        dst_plane_stride_d = dst_plane_stride_q;
        src_plane_base_d   = src_plane_base_q;
        dst_plane_base_d   = dst_plane_base_q;
        src_row_base_d     = src_row_base_q;
        dst_row_base_d     = dst_row_base_q;
        off_d              = off_q;
        row_d              = row_q;
        plane_d            = plane_q;
        wr_valid_d         = 1'b0;
        wr_addr_d          = wr_addr_q;
        wr_mask_d          = wr_mask_q;
        if (accept) begin
            mode_d             = io.mode;
            error_d            = illegal_cmd;
            row_bytes_d        = io.row_bytes;
            row_count_d        = io.row_count;
            plane_count_d      = io.plane_count;
            src_row_stride_d   = io.src_row_stride;
            dst_row_stride_d   = io.dst_row_stride;
            src_plane_stride_d = io.src_plane_stride;
            dst_plane_stride_d = io.dst_plane_stride;
            src_plane_base_d   = io.src_base;
            dst_plane_base_d   = io.dst_base;
            src_row_base_d     = io.src_base;
            dst_row_base_d     = io.dst_base;
            off_d              = '0;
            row_d              = '0;
            plane_d            = '0;
        end else if (state_q == XFER) begin
            wr_valid_d = 1'b1;
            wr_addr_d  = dst_row_base_q + ADDR_WIDTH'(off_q);
            wr_mask_d  = rd_mask;
            if (!last_in_row) begin
                off_d = off_q + LEN_W'(4);
            end else begin
                off_d = '0;
                if (!last_row) begin
                    row_d          = row_q + CNT_W'(1);
                    src_row_base_d = src_row_base_q + ADDR_WIDTH'(src_row_stride_q);
                    dst_row_base_d = dst_row_base_q + ADDR_WIDTH'(dst_row_stride_q);
                end else begin
                    row_d            = '0;
                    plane_d          = plane_q + CNT_W'(1);
                    src_plane_base_d = src_plane_base_q + src_plane_stride_q;
                    dst_plane_base_d = dst_plane_base_q + dst_plane_stride_q;
                    src_row_base_d   = src_plane_base_q + src_plane_stride_q;
                    dst_row_base_d   = dst_plane_base_q + dst_plane_stride_q;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q             <= 1'b0;
            error_q            <= 1'b0;
            row_bytes_q        <= '0;
            row_count_q        <= '0;
            plane_count_q      <= '0;
            src_row_stride_q   <= '0;
            dst_row_stride_q   <= '0;
            src_plane_stride_q <= '0;
            dst_plane_stride_q <= '0;
            src_plane_base_q   <= '0;
            dst_plane_base_q   <= '0;
            src_row_base_q     <= '0;
            dst_row_base_q     <= '0;
            off_q              <= '0;
            row_q              <= '0;
            plane_q            <= '0;
            wr_valid_q         <= 1'b0;
            wr_addr_q          <= '0;
            wr_mask_q          <= '0;
        end else begin
            mode_q             <= mode_d;
            error_q            <= error_d;
            row_bytes_q        <= row_bytes_d;
            row_count_q        <= row_count_d;
            plane_count_q      <= plane_count_d;
            src_row_stride_q   <= src_row_stride_d;
            dst_row_stride_q   <= dst_row_stride_d;
            src_plane_stride_q <= src_plane_stride_d;
            dst_plane_stride_q <= dst_plane_stride_d;
            src_plane_base_q   <= src_plane_base_d;
            dst_plane_base_q   <= dst_plane_base_d;
            src_row_base_q     <= src_row_base_d;
            dst_row_base_q     <= dst_row_base_d;
            off_q              <= off_d;
            row_q              <= row_d;
            plane_q            <= plane_d;
            wr_valid_q         <= wr_valid_d;
            wr_addr_q          <= wr_addr_d;
            wr_mask_q          <= wr_mask_d;
        end
    end

    // Load reads DRAM / writes GLB; store reads GLB / writes DRAM, so no port sees both at once.
    always_comb begin
        io.busy        = (state_q == XFER) || (state_q == DRAIN);
        io.finish      = (state_q == DONE);
        io.error       = error_q;
        io.dram_we     = 1'b0;
        io.dram_addr   = '0;
        io.dram_w_data = '0;
        io.glb_re      = 4'b0000;
        io.glb_we      = 4'b0000;
        io.glb_r_addr  = '0;
        io.glb_w_addr  = '0;
        io.glb_w_data  = '0;
        if (!mode_q) begin
            if (state_q == XFER) io.dram_addr = rd_addr;
            if (wr_valid_q) begin
                io.glb_we     = wr_mask_q;
                io.glb_w_addr = wr_addr_q;
                io.glb_w_data = wr_data;
            end
        end else begin
            if (state_q == XFER) begin
                io.glb_re     = 4'b1111;
                io.glb_r_addr = rd_addr;
            end
            if (wr_valid_q) begin
                io.dram_we     = 1'b1;
                io.dram_addr   = wr_addr_q;
                io.dram_w_data = wr_data;
            end
        end
    end

`ifdef TILE_DMA_CHECKSUM_EN
    logic [31:0] checksum_q, checksum_d;
    logic [31:0] lane_val [4];

    generate
        for (gi = 0; gi < 4; gi++) begin : g_csum
            assign lane_val[gi] = wr_mask_q[gi] ? 32'(wr_data[gi*DATA_WIDTH +: DATA_WIDTH]) : 32'd0;
        end
    endgenerate

    always_comb begin
        checksum_d = checksum_q;
        if (accept)          checksum_d = '0;
        else if (wr_valid_q) checksum_d = checksum_q + lane_val[0] + lane_val[1] + lane_val[2] + lane_val[3];
    end

    always_ff @(posedge clk) begin
        if (rst) checksum_q <= '0;
        else     checksum_q <= checksum_d;
    end

    assign io.checksum = checksum_q;
`else
    assign io.checksum = '0;
`endif
endmodule

// File: tb/tb_tile_dma.sv
// Self-checking bench for tile_dma: byte-addressed memory models plus a write scoreboard.
`timescale 1ns/1ps
module tb_tile_dma;
    localparam int AW  = 32;
    localparam int DW  = 8;
    localparam int LW  = 16;
    localparam int CW  = 10;
    localparam int MEM = 4096;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tile_dma_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_W(LW), .CNT_W(CW)) io ();
    tile_dma #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_W(LW), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .io  (io)
    );

    logic [7:0] dram_mem [MEM];
    logic [7:0] glb_mem  [MEM];

    typedef struct {
        logic        st;
        logic [31:0] addr;
        logic [3:0]  mask;
        logic [31:0] data;
    } wr_t;
    wr_t exp_q [$];

    int n_checks = 0;
    int n_errors = 0;
    int glb_rd_cnt = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] byte_mask(input logic [3:0] m);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = m[i] ? 8'hFF : 8'h00;
        return r;
    endfunction

    // 1-cycle read latency memories; lane i holds the byte at addr+i.
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            io.dram_r_data[8*i +: 8] <= dram_mem[(io.dram_addr + 32'(i)) % MEM];
            io.glb_r_data[8*i +: 8]  <= glb_mem[(io.glb_r_addr + 32'(i)) % MEM];
        end
    end

    always @(negedge clk) begin : monitor
        wr_t e;
        logic [31:0] bm;
        if (io.glb_we != 4'b0000 || io.dram_we) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", 1, 0);
            end else begin
                e = exp_q.pop_front();
                if (e.st) begin
                    check("dram_we", io.dram_we, 1);
                    check("store_glb_we", io.glb_we, 0);
                    check("dram_addr", io.dram_addr, e.addr);
                    check("dram_w_data", io.dram_w_data, e.data);
                end else begin
                    bm = byte_mask(e.mask);
                    check("load_dram_we", io.dram_we, 0);
                    check("glb_we_mask", io.glb_we, e.mask);
                    check("glb_w_addr", io.glb_w_addr, e.addr);
                    check("glb_w_data", io.glb_w_data & bm, e.data & bm);
                end
                $display("wr st=%0d addr=0x%0h mask=%b", e.st, e.addr, e.mask);
            end
            for (int i = 0; i < 4; i++) begin
                if (io.dram_we) dram_mem[(io.dram_addr + 32'(i)) % MEM] = io.dram_w_data[8*i +: 8];
                if (io.glb_we[i]) glb_mem[(io.glb_w_addr + 32'(i)) % MEM] = io.glb_w_data[8*i +: 8];
            end
        end
        if (io.glb_re != 4'b0000) begin
            glb_rd_cnt++;
            if (io.glb_we != 4'b0000) check("glb_rw_same_cycle", 1, 0);
        end
    end

    // Called at a negedge; start is sampled at the next posedge (edge 0).
    task automatic run_cmd(input logic m, input logic [31:0] sb, input logic [31:0] db,
                           input logic [15:0] rb, input logic [9:0] rc, input logic [9:0] pc,
                           input logic [15:0] srs, input logic [15:0] drs,
                           input logic [31:0] sps, input logic [31:0] dps,
                           input logic exp_err, input int rst_at);
        wr_t e;
        int n, nb, cyc, exp_fin;
        logic [31:0] sa, csum;
        logic [7:0] b;
        logic illegal, zero;
        illegal = m && (rb[1:0] != 2'b00);
        zero    = (rb == 0) || (rc == 0) || (pc == 0);
        n = 0;
        csum = 0;
        if (!illegal && !zero) begin
            for (int p = 0; p < int'(pc); p++)
                for (int r = 0; r < int'(rc); r++)
                    for (int off = 0; off < int'(rb); off += 4) begin
                        nb = (int'(rb) - off < 4) ? int'(rb) - off : 4;
                        sa = sb + 32'(p) * sps + 32'(r) * 32'(srs) + 32'(off);
                        e.st   = m;
                        e.addr = db + 32'(p) * dps + 32'(r) * 32'(drs) + 32'(off);
                        e.mask = 4'((1 << nb) - 1);
                        for (int i = 0; i < 4; i++) begin
                            b = m ? glb_mem[(sa + 32'(i)) % MEM] : dram_mem[(sa + 32'(i)) % MEM];
                            e.data[8*i +: 8] = b;
                            if (i < nb) csum += 32'(b);
                        end
                        exp_q.push_back(e);
                        n++;
                    end
        end
        exp_fin = (illegal || zero) ? 1 : n + 2;
        $display("cmd mode=%0d rb=%0d rc=%0d pc=%0d beats=%0d", m, rb, rc, pc, n);
        io.mode = m;               io.src_base = sb;           io.dst_base = db;
        io.row_bytes = rb;         io.row_count = rc;          io.plane_count = pc;
        io.src_row_stride = srs;   io.dst_row_stride = drs;
        io.src_plane_stride = sps; io.dst_plane_stride = dps;
        io.start = 1'b1;
        glb_rd_cnt = 0;
        @(negedge clk);
        io.start = 1'b0;
        cyc = 1;
        if (n > 0) check("busy_cycle1", io.busy, 1);
        while (!io.finish && cyc < n + 50) begin
            if (rst_at != 0 && cyc == rst_at) rst = 1'b1;
            @(negedge clk);
            cyc++;
            if (rst) begin
                check("rst_busy", io.busy, 0);
                check("rst_finish_error", {io.finish, io.error}, 0);
                check("rst_we_re", {io.dram_we, io.glb_we, io.glb_re}, 0);
                check("rst_dram_addr", io.dram_addr, 0);
                check("rst_glb_addrs", {io.glb_r_addr, io.glb_w_addr}, 0);
                check("rst_data", {io.glb_w_data, io.dram_w_data}, 0);
                check("rst_checksum", io.checksum, 0);
                check("rst_dropped_beats", exp_q.size(), n - (rst_at - 1));
                exp_q.delete();
                rst = 1'b0;
                return;
            end
        end
        check("finish_cycle", cyc, exp_fin);
        check("error", io.error, exp_err);
        check("busy_at_finish", io.busy, 0);
        check("scoreboard_empty", exp_q.size(), 0);
        check("glb_read_beats", glb_rd_cnt, m ? n : 0);
`ifdef TILE_DMA_CHECKSUM_EN
        check("checksum", io.checksum, csum);
`else
        check("checksum_zero", io.checksum, 0);
`endif
        $display("done finish_cycle=%0d error=%0d checksum=%0d", cyc, io.error, io.checksum);
        @(negedge clk);
        check("finish_one_cycle", io.finish, 0);
    endtask

    initial begin
        int mism;
        logic [23:0] tail_before;
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int mism;
        logic [23:0] tail_before;
        for (int i = 0; i < MEM; i++) begin
            dram_mem[i] = 8'($urandom);
            glb_mem[i]  = 8'($urandom);
        end
        io.start = 0; io.mode = 0; io.src_base = 0; io.dst_base = 0;
        io.row_bytes = 0; io.row_count = 0; io.plane_count = 0;
        io.src_row_stride = 0; io.dst_row_stride = 0;
        io.src_plane_stride = 0; io.dst_plane_stride = 0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_status", {io.busy, io.finish, io.error}, 0);
        check("reset_strobes", {io.dram_we, io.glb_re, io.glb_we}, 0);
        check("reset_addrs", {io.dram_addr, io.glb_w_addr}, 0);
        check("reset_checksum", io.checksum, 0);
        rst = 1'b0;
        @(negedge clk);

        // Load 12-byte rows, unaligned source stride.
        run_cmd(0, 0, 100, 12, 2, 1, 34, 12, 0, 0, 0, 0);
        mism = 0;
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < 12; i++)
                if (glb_mem[100 + r*12 + i] !== dram_mem[r*34 + i]) mism++;
        check("load1_region", mism, 0);

        // Load 9-byte rows: tail beats carry one byte.
        tail_before = {glb_mem[356], glb_mem[355], glb_mem[354]};
        run_cmd(0, 200, 300, 9, 3, 2, 34, 9, 1156, 27, 0, 0);
        mism = 0;
        for (int p = 0; p < 2; p++)
            for (int r = 0; r < 3; r++)
                for (int i = 0; i < 9; i++)
                    if (glb_mem[300 + p*27 + r*9 + i] !== dram_mem[200 + p*1156 + r*34 + i]) mism++;
        check("load2_region", mism, 0);
        check("load2_tail_untouched", {glb_mem[356], glb_mem[355], glb_mem[354]}, tail_before);

        // Store a 16x128-byte psum block.
        run_cmd(1, 1024, 2048, 128, 16, 1, 128, 128, 0, 0, 0, 0);
        mism = 0;
        for (int i = 0; i < 2048; i++)
            if (dram_mem[2048 + i] !== glb_mem[1024 + i]) mism++;
        check("store_region", mism, 0);

        // Illegal store, then a legal load clears error.
        run_cmd(1, 0, 0, 6, 1, 1, 8, 8, 0, 0, 1, 0);
        run_cmd(0, 40, 600, 4, 1, 1, 4, 4, 0, 0, 0, 0);

        // Zero-length command.
        run_cmd(0, 0, 0, 16, 0, 1, 16, 16, 0, 0, 0, 0);

        // Reset mid-transfer, then an immediate start with bytes 1..16.
        for (int i = 0; i < 16; i++) dram_mem[3000 + i] = 8'(i + 1);
        run_cmd(0, 0, 2000, 20, 4, 1, 20, 20, 0, 0, 0, 5);
        run_cmd(0, 3000, 500, 16, 1, 1, 16, 16, 0, 0, 0, 0);
`ifdef TILE_DMA_CHECKSUM_EN
        check("checksum_136", io.checksum, 136);
`endif
        mism = 0;
        for (int i = 0; i < 16; i++)
            if (glb_mem[500 + i] !== 8'(i + 1)) mism++;
        check("post_reset_load", mism, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
